bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, SHALL set the width of bus data, addresses and response data.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, SHALL set the width of bus and requester tags.
REQ-003 Parameter BEATS, default 8, SHALL set the number of response beats per transaction (power of two).
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: reset SHALL be asynchronous and active-high.
REQ-006 Port req_valid, input, 2: per-requester request (bit 0 instruction fetch, bit 1 data); held with stable address and tag until granted.
REQ-007 Ports req_addr0/req_addr1, input, BUS_DATA_WIDTH: request line addresses.
REQ-008 Ports req_tag0/req_tag1, input, BUS_TAG_WIDTH: request tags.
REQ-009 Port req_grant, output, 2: one-cycle pulse to the requester whose request the bus accepted.
REQ-010 Port resp_valid, output, 2: per-requester response beat strobe.
REQ-011 Port resp_data, output, BUS_DATA_WIDTH: current beat data, shared by both requesters.
REQ-012 Port resp_last, output, 1: marks the final beat.
REQ-013 Ports bus_reqcyc, bus_req, bus_reqtag, bus_respack (outputs) and bus_reqack, bus_respcyc, bus_resp, bus_resptag (inputs) SHALL carry the system bus signals at standard widths.

Function
REQ-014 The FSM SHALL have states IDLE, REQ and RESP.
REQ-015 IDLE: with any req_valid set, the block SHALL latch the chosen owner and enter REQ on the next edge.
REQ-016 Owner selection SHALL follow the policy in Configuration and be evaluated only in IDLE.
REQ-017 REQ: bus_reqcyc=1, bus_req/bus_reqtag = the owner's address/tag; otherwise bus_req and bus_reqtag SHALL be 0.
REQ-018 REQ with bus_reqack=1: req_grant[owner]=1 in that cycle (combinational), beat counter cleared, transition to RESP.
REQ-019 REQ with bus_reqack=0: the state SHALL hold indefinitely; the owner SHALL NOT change.
REQ-020 RESP: bus_respack = bus_respcyc and resp_valid[owner] = bus_respcyc, both combinational; resp_data = bus_resp.
REQ-021 Each accepted beat SHALL increment a log2(BEATS)-bit counter, wrapping from BEATS-1 to 0.
REQ-022 resp_last SHALL be 1 when counter==BEATS-1 and bus_respcyc=1; that edge SHALL return the FSM to IDLE.
REQ-023 Back-to-back: a request pending at the final beat SHALL enter REQ one cycle later (IDLE visited for exactly one cycle).
REQ-024 bus_respcyc in IDLE or REQ SHALL be ignored: bus_respack=0, resp_valid=0.
REQ-025 A requester deasserting req_valid before its grant is a protocol violation; behaviour is unspecified.
REQ-026 Only one transaction SHALL be outstanding at a time.

Reset
REQ-027 On reset: state IDLE, counter 0, owner 0, last-served pointer 1 (requester 0 preferred first); all outputs 0.
REQ-028 Reset asserted mid-REQ or mid-RESP SHALL abort the transaction immediately; remaining beats after release SHALL be ignored per REQ-024.

Configuration
REQ-029 Macro BUS_ARB_RR_EN defined: simultaneous requests SHALL alternate; the requester not served last wins, and the pointer updates at grant.
REQ-030 BUS_ARB_RR_EN undefined: fixed priority; requester 1 (data) SHALL always win ties; the pointer is absent.

Verification
REQ-031 Single fetch: req_valid=01, addr0=0x1000, tag0=0x100, bus_reqack on cycle 3 -> bus_req=0x1000, bus_reqtag=0x100, req_grant=01 on cycle 3, 8 resp_valid[0] beats, resp_last on the 8th.
REQ-032 Tie under BUS_ARB_RR_EN: req_valid=11 held for three transactions -> owners 0,1,0 with no beats misrouted; without the macro -> owners 1,1,1.
REQ-033 Stall: bus_reqack withheld 20 cycles -> bus_reqcyc held high, bus_req stable, no req_grant.
REQ-034 Gapped response: bus_respcyc toggles 1,0,1,... -> bus_respack mirrors it and the counter advances only on high cycles; resp_last on the 8th high cycle.
REQ-035 Reset after beat 3 -> outputs 0 asynchronously; spurious bus_respcyc afterwards gives no resp_valid; the next request completes normally.
REQ-036 Stray bus_respcyc=1 in IDLE -> bus_respack=0, resp_valid=00, state unchanged.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester (fetch/data) arbiter in front of a single
// split request/response system bus. One transaction is outstanding at a time.
// A transaction is a request phase followed by BEATS response beats.
// Optional feature: define BUS_ARB_RR_EN for round-robin tie breaking.
// When it is undefined, requester 1 (data) always wins a tie.
module bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    // requester side
    input  logic [1:0]                req_valid,
    input  logic [BUS_DATA_WIDTH-1:0] req_addr0,
    input  logic [BUS_DATA_WIDTH-1:0] req_addr1,
    input  logic [BUS_TAG_WIDTH-1:0]  req_tag0,
    input  logic [BUS_TAG_WIDTH-1:0]  req_tag1,
    output logic [1:0]                req_grant,
    output logic [1:0]                resp_valid,
    output logic [BUS_DATA_WIDTH-1:0] resp_data,
    output logic                      resp_last,
    // system bus side
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             owner_q;
    logic             pick;
    logic [CNT_W-1:0] count_q;
    logic             last_beat;

    // Response tags are not checked: with one outstanding transaction the
    // owner is already known.
    logic             unused_resptag;
    assign unused_resptag = ^bus_resptag;

    assign last_beat = (count_q == CNT_W'(BEATS - 1));

`ifdef BUS_ARB_RR_EN
    logic last_served_q;

    // Owner selection: a tie goes to the requester not served last.
    always_comb begin
        pick = owner_q;
        case (req_valid)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_served_q;
            default: pick = owner_q;
        endcase
    end

    // Last-served pointer updates when the bus accepts the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_served_q <= 1'b1;
        end else if (state_q == ST_REQ && bus_reqack) begin
            last_served_q <= owner_q;
        end
    end
`else
    // Owner selection: fixed priority, data requester wins a tie.
    always_comb begin
        pick = owner_q;
        case (req_valid)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = 1'b1;
            default: pick = owner_q;
        endcase
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bus/requester output decode.
    always_comb begin
        state_d     = state_q;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        req_grant   = 2'b00;
        bus_respack = 1'b0;
        resp_valid  = 2'b00;
        resp_data   = '0;
        resp_last   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_reqcyc = 1'b1;
                bus_req    = owner_q ? req_addr1 : req_addr0;
                bus_reqtag = owner_q ? req_tag1 : req_tag0;
                if (bus_reqack) begin
                    req_grant = {owner_q, ~owner_q};
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                bus_respack = bus_respcyc;
                resp_data   = bus_resp;
                if (bus_respcyc) begin
                    resp_valid = {owner_q, ~owner_q};
                    resp_last  = last_beat;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Owner latch (IDLE only) and response beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (state_q == ST_IDLE && (|req_valid)) begin
                owner_q <= pick;
            end
            if (state_q == ST_REQ && bus_reqack) begin
                count_q <= '0;
            end else if (state_q == ST_RESP && bus_respcyc) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

endmodule
